air_conditioning_zoned: RTL and testbench
=========================================

// Module: air_conditioning_zoned
// PURPOSE
//   Multi-zone, parametrised successor of the single-zone air-conditioning controller.
//   Runs one independent IDLE/HEAT/COOL hysteresis FSM per zone and adds three things:
//   a minimum-dwell (anti-short-cycle) timer, sensor-fault forcing and a global enable.
//   Sits between the zone temperature sensors and the HVAC plant drivers.
// PARAMETERS
//   N_ZONES     4   number of independent zones (>=1)
//   TEMP_W      5   temperature sample width, unsigned degrees C
//   LOWER_TEMP  18  heat-on threshold (t <= LOWER_TEMP)
//   MID_TEMP    20  return-to-idle point for both heat and cool
//   UPPER_TEMP  22  cool-on threshold (t >= UPPER_TEMP)
//   MIN_DWELL   8   minimum cycles a zone holds a state before a normal change (>=1)
//   Legal iff LOWER_TEMP < MID_TEMP < UPPER_TEMP < 2**TEMP_W-1; elaboration error otherwise.
// PORTS
//   clk          in   1                 single clock, rising edge
//   rst          in   1                 synchronous, active-high reset
//   enable       in   1                 0 = force all zones to IDLE
//   temperature  in   N_ZONES*TEMP_W    zone z at [z*TEMP_W +: TEMP_W]
//   heating      out  N_ZONES           registered, one bit per zone
//   cooling      out  N_ZONES           registered, one bit per zone
//   fault        out  N_ZONES           registered; sensor reading all-ones
//   n_active     out  $clog2(N_ZONES+1) count of zones heating or cooling
// BEHAVIOUR
//   - Reset (rst=1 at an edge):
//     - All zones go to IDLE.
//     - heating, cooling and fault are all 0.
//     - The dwell counter is loaded with MIN_DWELL-1, so the first decision after reset is immediate.
//   - Per-zone states: IDLE {h,c}=00, HEAT 10, COOL 01. The value 11 is never driven.
//   - Zone transitions, taken only when the move is permitted (dwell rule below):
//     - IDLE: t <= LOWER_TEMP -> HEAT; t >= UPPER_TEMP -> COOL; otherwise stay.
//     - HEAT: t >= MID_TEMP -> IDLE; otherwise stay.
//     - COOL: t <= MID_TEMP -> IDLE; otherwise stay.
//     - There is no direct HEAT<->COOL move; a zone always passes through IDLE.
//   - Comparisons are unsigned at full TEMP_W width.
//   - Dwell counter, one per zone:
//     - Cleared to 0 on every edge where the zone's state changes.
//     - Otherwise increments, saturating at MIN_DWELL-1.
//     - A normal move is permitted only when the pre-edge count is MIN_DWELL-1.
//     - Result: every state is visible for at least MIN_DWELL cycles.
//     - MIN_DWELL=1 gives a decision on every edge.
//   - Latency: a temperature sample at edge k drives the outputs after edge k (1 cycle).
//     The dwell rule may add further delay.
//   - Fault: temperature == 2**TEMP_W-1 at an edge means a sensor fault.
//     - fault[z] <= 1 at that edge.
//     - The zone is forced to IDLE, ignoring dwell. The counter is cleared if the state changed.
//     - fault[z] <= 0 at the first edge where the input is not all-ones.
//     - After the fault clears, the dwell rule runs normally from the forced entry.
//   - enable=0 at an edge: every zone is forced to IDLE, ignoring dwell.
//     - Counters are loaded with MIN_DWELL-1, so the zone may act on the first edge with enable=1.
//     - Fault detection still updates fault.
//   - Priority: rst > enable=0 > fault > normal transition.
//   - Reset mid-dwell: the count is discarded; the zone returns to the reset state above.
//   - n_active is a combinational popcount of (heating | cooling).
//     It is consistent with the outputs in the same cycle, and equals N_ZONES when all zones are active.
// STRUCTURE
//   - Package ac_pkg:
//     - ac_state_t enum: IDLE=2'b00, COOL=2'b01, HEAT=2'b10.
//     - Default threshold constants.
//     - Function clog2.
//   - Sub-module ac_zone_ctrl: one zone's FSM, dwell counter and fault register.
//     Parameters are TEMP_W, the thresholds and MIN_DWELL.
//   - Top level:
//     - A generate loop of N_ZONES ac_zone_ctrl instances.
//     - Slicing of the temperature bus.
//     - The n_active popcount.
// TESTING (N_ZONES=2, MIN_DWELL=4, default thresholds)
//   1. Reset then z0 t=17: heating[0]=1 after the first edge. Hold t=25:
//      heating[0] stays 1 (no COOL jump).
//   2. Dwell: z0 enters HEAT at edge E, and t=21 is applied from E+1.
//      heating[0] is 1 through edge E+3 and drops after edge E+4 -> exactly 4 cycles.
//   3. Hysteresis: z1 t=22 gives COOL. Step t to 21 and hold: stays COOL.
//      Step t to 20: IDLE once dwell is met. Step t to 19 and hold: stays IDLE.
//   4. Fault: z0 in HEAT mid-dwell, then t=31.
//      heating[0]=0 and fault[0]=1 after the next edge. Then t=17: fault[0]=0 next edge,
//      heating[0]=1 no earlier than 4 cycles after the forced IDLE.
//   5. Enable: both zones active, n_active=2. Drop enable for 1 cycle:
//      all outputs 0 and n_active=0. Raise enable with z0 t=17: heating[0]=1 on the next edge.
//   6. Reset mid-operation: assert rst while z1 is COOL with count=1.
//      Outputs are 0 after the edge. Deassert rst with t=23: cooling[1]=1 on the first edge after.

Source files
------------

// File: rtl/air_conditioning_zoned_pkg.sv
// Shared types and constants for the zoned air-conditioning controller.
//   ac_state_t : per-zone state, encoded so that bit 1 = heating and bit 0 = cooling
//   DEF_*      : default parameter values used by the top level
//   clog2      : ceiling log2 usable in parameter expressions
package ac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        COOL = 2'b01,
        HEAT = 2'b10
    } ac_state_t;

    localparam int DEF_N_ZONES    = 4;
    localparam int DEF_TEMP_W     = 5;
    localparam int DEF_LOWER_TEMP = 18;
    localparam int DEF_MID_TEMP   = 20;
    localparam int DEF_UPPER_TEMP = 22;
    localparam int DEF_MIN_DWELL  = 8;

    // clog2(1) = 0, clog2(2) = 1, clog2(5) = 3
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/air_conditioning_zoned_if.sv
// Bundle between the zone sensors / plant drivers and the controller.
//   enable      : 0 forces every zone to IDLE
//   temperature : zone z at [z*TEMP_W +: TEMP_W], unsigned degrees C
//   heating     : one registered bit per zone
//   cooling     : one registered bit per zone
//   fault       : one registered bit per zone, set while the sensor reads all-ones
//   n_active    : number of zones currently heating or cooling
// master = environment side, slave = controller side.
interface air_conditioning_zoned_if #(
    parameter int N_ZONES = 4,
    parameter int TEMP_W  = 5
);
    import ac_pkg::*;

    localparam int NA_W = clog2(N_ZONES + 1);

    logic                        enable;
    logic [N_ZONES*TEMP_W-1:0]   temperature;
    logic [N_ZONES-1:0]          heating;
    logic [N_ZONES-1:0]          cooling;
    logic [N_ZONES-1:0]          fault;
    logic [NA_W-1:0]             n_active;

    modport master (
        output enable, temperature,
        input  heating, cooling, fault, n_active
    );

    modport slave (
        input  enable, temperature,
        output heating, cooling, fault, n_active
    );

endinterface

// File: rtl/air_conditioning_zoned_zone.sv
// One zone: IDLE/HEAT/COOL hysteresis FSM with a minimum-dwell counter and
// sensor-fault register.
//   clk, rst    : clock and synchronous active-high reset
//   enable      : 0 forces IDLE and preloads the dwell counter
//   temperature : this zone's sample
//   heating     : registered, zone is in HEAT
//   cooling     : registered, zone is in COOL
//   fault       : registered, last sample was all-ones
module ac_zone_ctrl
    import ac_pkg::*;
#(
    parameter int TEMP_W     = 5,
    parameter int LOWER_TEMP = 18,
    parameter int MID_TEMP   = 20,
    parameter int UPPER_TEMP = 22,
    parameter int MIN_DWELL  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [TEMP_W-1:0] temperature,
    output logic              heating,
    output logic              cooling,
    output logic              fault
);

    localparam int CNT_W = (MIN_DWELL > 1) ? clog2(MIN_DWELL) : 1;
    localparam logic [CNT_W-1:0]  DWELL_MAX = CNT_W'(MIN_DWELL - 1);
    localparam logic [TEMP_W-1:0] T_LO  = TEMP_W'(LOWER_TEMP);
    localparam logic [TEMP_W-1:0] T_MID = TEMP_W'(MID_TEMP);
    localparam logic [TEMP_W-1:0] T_UP  = TEMP_W'(UPPER_TEMP);

    ac_state_t        state;
    ac_state_t        state_next;
    logic [CNT_W-1:0] dwell;
    logic [CNT_W-1:0] dwell_inc;
    logic             dwell_done;
    logic             sensor_bad;

    assign sensor_bad = (temperature == '1);
    assign dwell_done = (dwell == DWELL_MAX);
    assign dwell_inc  = dwell_done ? dwell : dwell + CNT_W'(1);

    // Desired state from the hysteresis rules alone; dwell gating is applied below.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (temperature <= T_LO)
                    state_next = HEAT;
                else if (temperature >= T_UP)
                    state_next = COOL;
            end
            HEAT: if (temperature >= T_MID) state_next = IDLE;
            COOL: if (temperature <= T_MID) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            dwell <= DWELL_MAX;
            fault <= 1'b0;
        end else begin
            fault <= sensor_bad;
            if (!enable) begin
                // Preloaded so the zone can act on the first enabled edge.
                state <= IDLE;
                dwell <= DWELL_MAX;
            end else if (sensor_bad) begin
                state <= IDLE;
                dwell <= (state != IDLE) ? '0 : dwell_inc;
            end else if (dwell_done && (state_next != state)) begin
                state <= state_next;
                dwell <= '0;
            end else begin
                dwell <= dwell_inc;
            end
        end
    end

    assign heating = (state == HEAT);
    assign cooling = (state == COOL);

endmodule

// File: rtl/air_conditioning_zoned.sv
// Multi-zone air-conditioning controller: one ac_zone_ctrl per zone plus a
// count of active zones.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of air_conditioning_zoned_if (enable, temperature in;
//              heating, cooling, fault, n_active out)
module air_conditioning_zoned
    import ac_pkg::*;
#(
    parameter int N_ZONES    = DEF_N_ZONES,
    parameter int TEMP_W     = DEF_TEMP_W,
    parameter int LOWER_TEMP = DEF_LOWER_TEMP,
    parameter int MID_TEMP   = DEF_MID_TEMP,
    parameter int UPPER_TEMP = DEF_UPPER_TEMP,
    parameter int MIN_DWELL  = DEF_MIN_DWELL
) (
    input  logic clk,
    input  logic rst,
    air_conditioning_zoned_if.slave bus
);

    localparam int NA_W = clog2(N_ZONES + 1);

    if (!(N_ZONES >= 1 && MIN_DWELL >= 1 &&
          LOWER_TEMP < MID_TEMP && MID_TEMP < UPPER_TEMP &&
          UPPER_TEMP < (2**TEMP_W) - 1)) begin : g_bad_params
        $error("air_conditioning_zoned: illegal parameter set");
    end

    logic [N_ZONES-1:0] heat_v;
    logic [N_ZONES-1:0] cool_v;
    logic [N_ZONES-1:0] fault_v;
    logic [NA_W-1:0]    active_cnt;

    for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
        ac_zone_ctrl #(
            .TEMP_W     (TEMP_W),
            .LOWER_TEMP (LOWER_TEMP),
            .MID_TEMP   (MID_TEMP),
            .UPPER_TEMP (UPPER_TEMP),
            .MIN_DWELL  (MIN_DWELL)
        ) u_zone (
            .clk         (clk),
            .rst         (rst),
            .enable      (bus.enable),
            .temperature (bus.temperature[z*TEMP_W +: TEMP_W]),
            .heating     (heat_v[z]),
            .cooling     (cool_v[z]),
            .fault       (fault_v[z])
        );
    end

    always_comb begin
        active_cnt = '0;
        for (int z = 0; z < N_ZONES; z++)
            active_cnt = active_cnt + NA_W'(heat_v[z] | cool_v[z]);
    end

    assign bus.heating  = heat_v;
    assign bus.cooling  = cool_v;
    assign bus.fault    = fault_v;
    assign bus.n_active = active_cnt;

endmodule

// File: tb/tb_air_conditioning_zoned.sv
// Bench for air_conditioning_zoned: directed scenarios followed by random
// stimulus, all scored against a behavioural model of the zone rules.
module tb_air_conditioning_zoned;
    import ac_pkg::*;

    localparam int NZ  = 2;
    localparam int TW  = 5;
    localparam int MD  = 4;
    localparam int LO  = 18;
    localparam int MID = 20;
    localparam int UP  = 22;
    localparam int TMAX = (2**TW) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    air_conditioning_zoned_if #(.N_ZONES(NZ), .TEMP_W(TW)) bus();

    air_conditioning_zoned #(
        .N_ZONES(NZ), .TEMP_W(TW), .LOWER_TEMP(LO),
        .MID_TEMP(MID), .UPPER_TEMP(UP), .MIN_DWELL(MD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [NZ-1:0] h;
        logic [NZ-1:0] c;
        logic [NZ-1:0] f;
        int            n;
    } exp_t;

    exp_t sb[$];

    // Model: mode 0 = idle, 1 = heat, 2 = cool; age = edges spent in the mode.
    int m_mode[NZ];
    int m_age[NZ];
    bit m_flt[NZ];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int want_mode(input int mode, input int t);
        if (mode == 0) return (t <= LO) ? 1 : ((t >= UP) ? 2 : 0);
        if (mode == 1) return (t >= MID) ? 0 : 1;
        return (t <= MID) ? 0 : 2;
    endfunction

    task automatic model_edge(input logic e, input logic r, input int t0, input int t1);
        exp_t x;
        int   t;
        int   w;
        x.h = '0; x.c = '0; x.f = '0; x.n = 0;
        for (int z = 0; z < NZ; z++) begin
            t = (z == 0) ? t0 : t1;
            if (r) begin
                m_mode[z] = 0; m_age[z] = MD; m_flt[z] = 0;
            end else begin
                m_flt[z] = (t == TMAX);
                if (!e) begin
                    m_mode[z] = 0; m_age[z] = MD;
                end else if (m_flt[z]) begin
                    if (m_mode[z] != 0) begin m_mode[z] = 0; m_age[z] = 0; end
                    else m_age[z]++;
                end else begin
                    w = want_mode(m_mode[z], t);
                    if (w != m_mode[z] && m_age[z] >= MD - 1) begin
                        m_mode[z] = w; m_age[z] = 0;
                    end else begin
                        m_age[z]++;
                    end
                end
                if (m_age[z] > MD) m_age[z] = MD;
            end
            x.h[z] = (m_mode[z] == 1);
            x.c[z] = (m_mode[z] == 2);
            x.f[z] = m_flt[z];
            if (m_mode[z] != 0) x.n++;
        end
        sb.push_back(x);
    endtask

    task automatic step(input logic e, input logic r, input int t0, input int t1);
        @(negedge clk);
        rst             = r;
        bus.enable      = e;
        bus.temperature = {TW'(t1), TW'(t0)};
        model_edge(e, r, t0, t1);
    endtask

    // Wait until just after the edge that applies the last step.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard monitor: one expected entry per active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_heating",  32'(bus.heating),  32'(e.h));
                chk("sb_cooling",  32'(bus.cooling),  32'(e.c));
                chk("sb_fault",    32'(bus.fault),    32'(e.f));
                chk("sb_n_active", 32'(bus.n_active), 32'(e.n));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int t0, t1;
        logic e, r;
        rst             = 1'b1;
        bus.enable      = 1'b1;
        bus.temperature = '0;

        // Reset state
        step(1, 1, 20, 20);
        settle();
        chk("rst_heating", 32'(bus.heating), 0);
        chk("rst_cooling", 32'(bus.cooling), 0);
        chk("rst_fault",   32'(bus.fault),   0);

        // Immediate heat after reset, no jump to cool, exact dwell
        step(1, 0, 17, 20);
        settle(); chk("heat_first", 32'(bus.heating[0]), 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, (i == 0) ? 25 : 21, 20);
            settle();
            chk("heat_dwell", 32'(bus.heating[0]), 1);
            chk("no_cool_jump", 32'(bus.cooling[0]), 0);
        end
        step(1, 0, 21, 20);
        settle(); chk("heat_release", 32'(bus.heating[0]), 0);

        // Both zones active
        step(1, 0, 20, 25);
        settle(); chk("z1_cool", 32'(bus.cooling[1]), 1);
        step(1, 0, 20, 25);
        step(1, 0, 20, 25);
        step(1, 0, 17, 25);
        settle(); chk("n_active_two", 32'(bus.n_active), 2);

        // Enable drop
        step(0, 0, 17, 25);
        settle();
        chk("en_heating",  32'(bus.heating),  0);
        chk("en_cooling",  32'(bus.cooling),  0);
        chk("en_n_active", 32'(bus.n_active), 0);
        step(1, 0, 17, 20);
        settle(); chk("en_resume", 32'(bus.heating[0]), 1);

        // Sensor fault mid-dwell
        step(1, 0, 31, 20);
        settle();
        chk("flt_heating", 32'(bus.heating[0]), 0);
        chk("flt_set",     32'(bus.fault[0]),   1);
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 17, 20);
            settle();
            chk("flt_clear", 32'(bus.fault[0]), 0);
            chk("flt_redwell", 32'(bus.heating[0]), (i == 4) ? 1 : 0);
        end

        // Hysteresis on zone 1
        step(1, 0, 20, 22);
        settle(); chk("hys_cool_on", 32'(bus.cooling[1]), 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 20, 21);
            settle(); chk("hys_hold_cool", 32'(bus.cooling[1]), 1);
        end
        step(1, 0, 20, 20);
        settle(); chk("hys_idle", 32'(bus.cooling[1]), 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 20, 19);
            settle();
            chk("hys_hold_idle_h", 32'(bus.heating[1]), 0);
            chk("hys_hold_idle_c", 32'(bus.cooling[1]), 0);
        end

        // Reset mid-dwell
        step(1, 0, 20, 25);
        step(1, 0, 20, 25);
        step(1, 1, 20, 25);
        settle();
        chk("rst_mid_c", 32'(bus.cooling), 0);
        chk("rst_mid_h", 32'(bus.heating), 0);
        step(1, 0, 20, 23);
        settle(); chk("rst_resume", 32'(bus.cooling[1]), 1);

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            e  = ($urandom_range(0, 29) != 0);
            t0 = ($urandom_range(0, 19) == 0) ? TMAX : int'($urandom_range(14, 26));
            t1 = ($urandom_range(0, 19) == 0) ? TMAX : int'($urandom_range(0, TMAX));
            step(e, r, t0, t1);
        end

        settle();
        settle();
        chk("sb_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
